// File: rtl/mole_hole_ctrl.sv
// Per-hole mole lifecycle: spawn -> rise -> up -> sink, or a whack that shows an injured mole.
// One cycle from event to output; all outputs are registered, with no backpressure (whack and tick are never stalled).
module mole_hole_ctrl #(
    parameter int TW         = 12,
    parameter int RISE_TICKS = 250,
    parameter int SINK_TICKS = 250,
    parameter int HIT_TICKS  = 500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          game_en,
    input  logic          spawn,
    input  logic          whack,
    input  logic [TW-1:0] up_ticks,
    output logic [1:0]    mole_state,
    output logic          busy,
    output logic          hit,
    output logic          miss
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_UP,
        S_SINK,
        S_HIT
    } state_t;

    // A duration of 0 behaves like 1, so the load value is clamped at 0.
    localparam logic [TW-1:0] RISE_LOAD = TW'((RISE_TICKS > 1) ? RISE_TICKS - 1 : 0);
    localparam logic [TW-1:0] SINK_LOAD = TW'((SINK_TICKS > 1) ? SINK_TICKS - 1 : 0);
    localparam logic [TW-1:0] HIT_LOAD  = TW'((HIT_TICKS  > 1) ? HIT_TICKS  - 1 : 0);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] up_load;
    logic [1:0]    mole_state_d;
    logic          busy_d, hit_d, miss_d;
    logic          phase_end;

    assign up_load   = (up_ticks == '0) ? '0 : up_ticks - TW'(1);
    assign phase_end = tick && (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        if (tick && (timer_q != '0)) begin
            timer_d = timer_q - TW'(1);
        end
        if (!game_en) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (spawn) begin
                        state_d = S_RISE;
                        timer_d = RISE_LOAD;
                    end
                end
                S_RISE: begin
                    if (whack) begin
                        state_d = S_HIT;
                        timer_d = HIT_LOAD;
                        hit_d   = 1'b1;
                    end else if (phase_end) begin
                        // up_ticks is captured here; the timer holds it for the whole UP phase.
                        state_d = S_UP;
                        timer_d = up_load;
                    end
                end
                S_UP: begin
                    if (whack) begin
                        state_d = S_HIT;
                        timer_d = HIT_LOAD;
                        hit_d   = 1'b1;
                    end else if (phase_end) begin
                        state_d = S_SINK;
                        timer_d = SINK_LOAD;
                        miss_d  = 1'b1;
                    end
                end
                S_SINK, S_HIT: begin
                    if (phase_end) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        case (state_d)
            S_RISE, S_SINK: mole_state_d = 2'd1;
            S_UP:           mole_state_d = 2'd2;
            S_HIT:          mole_state_d = 2'd3;
            default:        mole_state_d = 2'd0;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            mole_state <= 2'd0;
            busy       <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            mole_state <= mole_state_d;
            busy       <= busy_d;
            hit        <= hit_d;
            miss       <= miss_d;
        end
    end

endmodule

// File: tb/tb_mole_hole_ctrl.sv
// Directed bench for mole_hole_ctrl: the driver queues hand-computed outputs, and a monitor checks them one cycle later.
module tb_mole_hole_ctrl;

    localparam int TW = 12;
    localparam logic [63:0] ALL = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          game_en = 1'b0;
    logic          spawn = 1'b0;
    logic          whack = 1'b0;
    logic [TW-1:0] up_ticks = 12'd4;
    logic [1:0]    mole_state;
    logic          busy, hit, miss;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];
    string      name_q[$];
    int         cyc_q[$];

    mole_hole_ctrl #(
        .TW(TW),
        .RISE_TICKS(2),
        .SINK_TICKS(2),
        .HIT_TICKS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .game_en(game_en),
        .spawn(spawn),
        .whack(whack),
        .up_ticks(up_ticks),
        .mole_state(mole_state),
        .busy(busy),
        .hit(hit),
        .miss(miss)
    );

    always #5 clk = ~clk;

    // ms[k] is the expected mole_state at cycle k; inputs at cycle c produce outputs at c+1.
    task automatic run(input string name, input string ms,
                       input logic [63:0] sp, input logic [63:0] wh,
                       input logic [63:0] tk, input logic [63:0] ge,
                       input logic [63:0] rs, input logic [63:0] hm,
                       input logic [63:0] mm,
                       input logic [TW-1:0] up0, input logic [TW-1:0] up1,
                       input int upc);
        logic [7:0] ch;
        logic [4:0] e;
        int n;
        n = ms.len() - 1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            spawn    = sp[c];
            whack    = wh[c];
            tick     = tk[c];
            game_en  = ge[c];
            rst      = rs[c];
            up_ticks = (c >= upc) ? up1 : up0;
            ch = ms[c + 1];
            e  = {ch[1:0], (ch != 8'd48), hm[c + 1], mm[c + 1]};
            exp_q.push_back(e);
            name_q.push_back(name);
            cyc_q.push_back(c + 1);
        end
    endtask

    initial begin
        logic [4:0] e;
        logic [4:0] act;
        string      nm;
        int         cy;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cy = cyc_q.pop_front();
                act = {mole_state, busy, hit, miss};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s cycle %0d: got ms=%0d busy=%b hit=%b miss=%b, want ms=%0d busy=%b hit=%b miss=%b",
                             nm, cy, act[4:3], act[2], act[1], act[0], e[4:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [63:0] t4;
        for (int i = 0; i < 64; i++) t4[i] = ((i % 4) == 0);

        run("reset",         "000",           64'h3, 64'h3, ALL, ALL, 64'h3, 64'h0, 64'h0, 12'd4, 12'd4, 0);
        run("full_miss",     "0112222110",    64'h1, 64'h0, ALL, ALL, 64'h0, 64'h0, 64'h1 << 7, 12'd4, 12'd4, 0);
        run("hit_up",        "011223330",     64'h1, 64'h1 << 4, ALL, ALL, 64'h0, 64'h1 << 5, 64'h0, 12'd4, 12'd4, 0);
        run("whack_timeout", "01122223330",   64'h1, 64'h1 << 6, ALL, ALL, 64'h0, 64'h1 << 7, 64'h0, 12'd4, 12'd4, 0);
        run("ignore_sink",   "0112222110",    64'h9, (64'h1 << 7) | (64'h1 << 8), ALL, ALL, 64'h0, 64'h0, 64'h1 << 7, 12'd4, 12'd4, 0);
        run("ignore_hit",    "013330",        64'h9, 64'ha, ALL, ALL, 64'h0, 64'h1 << 2, 64'h0, 12'd4, 12'd4, 0);
        run("game_off",      "011220",        64'h1, 64'h1 << 4, ALL, ~(64'h1 << 4), 64'h0, 64'h0, 64'h0, 12'd4, 12'd4, 0);
        run("spawn_gen",     "000112222110",  64'h5, 64'h0, ALL, ~64'h3, 64'h0, 64'h0, 64'h1 << 9, 12'd4, 12'd4, 0);
        run("tick_gate",     "0111111112233333333330", 64'h1, 64'h1 << 10, t4, ALL, 64'h0, 64'h1 << 11, 64'h0, 12'd4, 12'd4, 0);
        run("rst_mid",       "01122220",      64'h1, 64'h0, ALL, ALL, 64'h1 << 6, 64'h0, 64'h0, 12'd4, 12'd4, 0);
        run("up_latch",      "0112222110",    64'h1, 64'h0, ALL, ALL, 64'h0, 64'h0, 64'h1 << 7, 12'd4, 12'd1, 4);
        run("up_zero",       "0112110",       64'h1, 64'h0, ALL, ALL, 64'h0, 64'h0, 64'h1 << 4, 12'd0, 12'd0, 0);

        @(negedge clk);
        spawn = 1'b0;
        whack = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
